// File: rtl/cbs_mc.sv
// rtl/cbs_mc.sv - multicycle core (FETCH/EXEC/MEM) with opd_32 decode, alu and cmp blocks
// Optional performance counters are built only when CBS_MC_PERF_EN is defined.

module opd_32 (
    input  logic [31:0] instr,
    output logic [3:0]  rc,
    output logic [3:0]  ra,
    output logic [3:0]  rb,
    output logic [15:0] imm,
    output logic [2:0]  alu_op,
    output logic [1:0]  cmp_op,
    output logic        use_imm,
    output logic        is_write,
    output logic        is_load,
    output logic        is_store,
    output logic        is_cmp
);
    // op[31:28] rc[27:24] ra[23:20] rb[19:16] imm[15:0]
    assign rc  = instr[27:24];
    assign ra  = instr[23:20];
    assign rb  = instr[19:16];
    assign imm = instr[15:0];

    always_comb begin
        alu_op   = 3'd0;
        cmp_op   = 2'd0;
        use_imm  = 1'b0;
        is_write = 1'b0;
        is_load  = 1'b0;
        is_store = 1'b0;
        is_cmp   = 1'b0;
        case (instr[31:28])
            4'd1:    begin alu_op = 3'd0; is_write = 1'b1; end
            4'd2:    begin alu_op = 3'd1; is_write = 1'b1; end
            4'd3:    begin alu_op = 3'd2; is_write = 1'b1; end
            4'd4:    begin alu_op = 3'd3; is_write = 1'b1; end
            4'd5:    begin alu_op = 3'd4; is_write = 1'b1; end
            4'd6:    begin use_imm = 1'b1; is_write = 1'b1; end
            4'd7:    begin use_imm = 1'b1; is_load = 1'b1; end
            4'd8:    begin use_imm = 1'b1; is_store = 1'b1; end
            4'd9:    begin cmp_op = 2'd0; is_cmp = 1'b1; end
            4'd10:   begin cmp_op = 2'd1; is_cmp = 1'b1; end
            4'd11:   begin cmp_op = 2'd2; is_cmp = 1'b1; end
            default: ;
        endcase
    end
endmodule

module alu #(
    parameter int W = 32
) (
    input  logic [2:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y
);
    always_comb begin
        case (op)
            3'd1:    y = a - b;
            3'd2:    y = a & b;
            3'd3:    y = a | b;
            3'd4:    y = a ^ b;
            default: y = a + b;
        endcase
    end
endmodule

module cmp #(
    parameter int W = 32
) (
    input  logic [1:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         taken
);
    always_comb begin
        case (op)
            2'd0:    taken = (a == b);
            2'd1:    taken = (a != b);
            2'd2:    taken = ($signed(a) < $signed(b));
            default: taken = 1'b0;
        endcase
    end
endmodule

module cbs_mc #(
    parameter int NUM_REG   = 8,
    parameter int REG_WIDTH = 32,
    parameter int NUM_INSTR = 16,
    parameter int NUM_MEM   = 16,
    localparam int INSTR_SELECT = $clog2(NUM_INSTR),
    localparam int MEM_SELECT   = $clog2(NUM_MEM)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_run,
    input  logic [NUM_INSTR*REG_WIDTH-1:0] i_instructions,
    output logic                           o_mem_req,
    output logic                           o_mem_we,
    output logic [MEM_SELECT-1:0]          o_mem_addr,
    output logic [REG_WIDTH-1:0]           o_mem_wdata,
    input  logic                           i_mem_ack,
    input  logic [REG_WIDTH-1:0]           i_mem_rdata,
    output logic                           o_retire,
    output logic [INSTR_SELECT-1:0]        o_pc,
    output logic [31:0]                    o_cycle_count,
    output logic [31:0]                    o_retired_count
);
    localparam int RSEL = $clog2(NUM_REG);

    typedef enum logic [1:0] {FETCH, EXEC, MEM} state_t;

    state_t                  state;
    logic [INSTR_SELECT-1:0] pc;
    logic [REG_WIDTH-1:0]    ir;
    logic [REG_WIDTH-1:0]    regs [NUM_REG];
    logic                    mem_req;
    logic                    mem_we;
    logic [MEM_SELECT-1:0]   mem_addr;
    logic [REG_WIDTH-1:0]    mem_wdata;
    logic                    retire;

    logic [3:0]  rc, ra, rb;
    logic [15:0] imm;
    logic [2:0]  alu_op;
    logic [1:0]  cmp_op;
    logic        use_imm, is_write, is_load, is_store, is_cmp;
    logic        cmp_taken;

    logic [REG_WIDTH-1:0]    fetch_word;
    logic [REG_WIDTH-1:0]    reg_a_val, reg_b_val, op_b, alu_y;
    logic [INSTR_SELECT-1:0] next_pc;
    logic [RSEL-1:0]         rc_i;

    opd_32 u_opd (
        .instr(ir[31:0]), .rc(rc), .ra(ra), .rb(rb), .imm(imm),
        .alu_op(alu_op), .cmp_op(cmp_op), .use_imm(use_imm),
        .is_write(is_write), .is_load(is_load), .is_store(is_store), .is_cmp(is_cmp)
    );

    assign fetch_word = i_instructions[32'(pc) * REG_WIDTH +: REG_WIDTH];
    assign reg_a_val  = regs[ra[RSEL-1:0]];
    assign reg_b_val  = regs[rb[RSEL-1:0]];
    assign rc_i       = rc[RSEL-1:0];
    assign op_b       = use_imm ? {{(REG_WIDTH-16){imm[15]}}, imm} : reg_b_val;

    alu #(.W(REG_WIDTH)) u_alu (.op(alu_op), .a(reg_a_val), .b(op_b), .y(alu_y));
    cmp #(.W(REG_WIDTH)) u_cmp (.op(cmp_op), .a(reg_a_val), .b(reg_b_val), .taken(cmp_taken));

    // Branch offset is truncated to the PC width so the target wraps modulo NUM_INSTR.
    assign next_pc = (is_cmp && cmp_taken) ? pc + imm[INSTR_SELECT-1:0] : pc + INSTR_SELECT'(1);

    // Register-index fields wider than the register file are simply ignored.
    logic unused_ok;
    assign unused_ok = ^{rc, ra, rb, ir};

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FETCH;
            pc        <= '0;
            ir        <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            retire    <= 1'b0;
            for (int i = 0; i < NUM_REG; i++) regs[i] <= '0;
        end else begin
            retire <= 1'b0;
            case (state)
                FETCH: begin
                    if (i_run) begin
                        ir    <= fetch_word;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    if (is_load || is_store) begin
                        mem_req   <= 1'b1;
                        mem_we    <= is_store;
                        mem_addr  <= alu_y[MEM_SELECT-1:0];
                        mem_wdata <= reg_b_val;
                        state     <= MEM;
                    end else begin
                        if (is_write) regs[rc_i] <= alu_y;
                        pc     <= next_pc;
                        retire <= 1'b1;
                        state  <= FETCH;
                    end
                end
                MEM: begin
                    if (i_mem_ack) begin
                        if (is_load) regs[rc_i] <= i_mem_rdata;
                        pc      <= pc + INSTR_SELECT'(1);
                        retire  <= 1'b1;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        state   <= FETCH;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

    assign o_mem_req   = mem_req;
    assign o_mem_we    = mem_we;
    assign o_mem_addr  = mem_addr;
    assign o_mem_wdata = mem_wdata;
    assign o_retire    = retire;
    assign o_pc        = pc;

`ifdef CBS_MC_PERF_EN
    logic [31:0] cycle_count;
    logic [31:0] retired_count;
    logic        retire_now;

    // Counted on the edge that raises o_retire so the count tracks the pulse exactly.
    assign retire_now = ((state == EXEC) && !(is_load || is_store)) || ((state == MEM) && i_mem_ack);

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_count   <= '0;
            retired_count <= '0;
        end else begin
            if (i_run || state != FETCH) cycle_count <= cycle_count + 32'd1;
            if (retire_now) retired_count <= retired_count + 32'd1;
        end
    end

    assign o_cycle_count   = cycle_count;
    assign o_retired_count = retired_count;
`else
    assign o_cycle_count   = '0;
    assign o_retired_count = '0;
`endif

endmodule

// File: tb/tb_cbs_mc.sv
// tb/tb_cbs_mc.sv - directed self-checking bench for cbs_mc
module tb_cbs_mc;
    localparam int NI = 16;
    localparam int W  = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            i_run;
    logic [NI*W-1:0] i_instructions;
    logic            o_mem_req;
    logic            o_mem_we;
    logic [3:0]      o_mem_addr;
    logic [W-1:0]    o_mem_wdata;
    logic            i_mem_ack;
    logic [W-1:0]    i_mem_rdata;
    logic            o_retire;
    logic [3:0]      o_pc;
    logic [31:0]     o_cycle_count;
    logic [31:0]     o_retired_count;

    int checks = 0;
    int errors = 0;

    cbs_mc dut (
        .clk(clk), .rst(rst), .i_run(i_run), .i_instructions(i_instructions),
        .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
        .o_mem_wdata(o_mem_wdata), .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata),
        .o_retire(o_retire), .o_pc(o_pc), .o_cycle_count(o_cycle_count),
        .o_retired_count(o_retired_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] enc(input int op, input int rc, input int ra, input int rb, input int imm);
        return {4'(op), 4'(rc), 4'(ra), 4'(rb), 16'(imm)};
    endfunction

    task automatic set_slot(input int k, input logic [31:0] word);
        i_instructions[k*W +: W] = word;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; i_run = 1'b0; i_mem_ack = 1'b0; i_mem_rdata = '0; i_instructions = '0;
        set_slot(0,  enc(6, 1, 0, 0, 5));   // r1 = r0 + 5
        set_slot(1,  enc(1, 2, 1, 1, 0));   // r2 = r1 + r1
        set_slot(2,  enc(8, 0, 0, 2, 3));   // mem[3] = r2
        set_slot(3,  enc(7, 3, 0, 0, 3));   // r3 = mem[3]
        set_slot(4,  enc(8, 0, 0, 3, 7));   // mem[7] = r3
        set_slot(5,  enc(9, 0, 0, 0, 10));  // beq -> 15
        set_slot(15, enc(9, 0, 0, 0, 2));   // beq -> 1 (wraps)
        tick(); tick();
        check("rst_pc", o_pc, 0);
        check("rst_req", o_mem_req, 0);
        check("rst_we", o_mem_we, 0);
        check("rst_addr", o_mem_addr, 0);
        check("rst_wdata", o_mem_wdata, 0);
        check("rst_retire", o_retire, 0);
        check("rst_cycles", o_cycle_count, 0);
        check("rst_retired", o_retired_count, 0);

        rst = 1'b0; i_run = 1'b1;
        tick(); check("c1_retire", o_retire, 0);
        tick(); check("c2_retire", o_retire, 1); check("c2_pc", o_pc, 1);
        tick(); check("c3_retire", o_retire, 0);
        tick(); check("c4_retire", o_retire, 1); check("c4_pc", o_pc, 2);

        // store r2 -> addr 3, ack in the 4th request cycle
        tick(); tick();
        check("st_req", o_mem_req, 1); check("st_we", o_mem_we, 1);
        check("st_addr", o_mem_addr, 3); check("st_wdata", o_mem_wdata, 10);
        check("st_pc_hold", o_pc, 2); check("st_noretire", o_retire, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("st_wait_req", o_mem_req, 1);
            check("st_wait_pc", o_pc, 2);
            check("st_wait_wdata", o_mem_wdata, 10);
        end
        i_mem_ack = 1'b1;
        tick(); i_mem_ack = 1'b0;
        check("st_done_req", o_mem_req, 0); check("st_done_retire", o_retire, 1);
        check("st_done_pc", o_pc, 3);

        // load mem[3] -> r3 with same-cycle ack
        tick(); tick();
        check("ld_req", o_mem_req, 1); check("ld_we", o_mem_we, 0); check("ld_addr", o_mem_addr, 3);
        i_mem_ack = 1'b1; i_mem_rdata = 32'hA5;
        tick(); i_mem_ack = 1'b0; i_mem_rdata = '0;
        check("ld_req_1cyc", o_mem_req, 0); check("ld_retire", o_retire, 1); check("ld_pc", o_pc, 4);

        // store r3 to expose the loaded value
        tick(); tick();
        check("st2_addr", o_mem_addr, 7); check("st2_wdata", o_mem_wdata, 32'hA5);
        i_mem_ack = 1'b1;
        tick(); i_mem_ack = 1'b0;
        check("st2_pc", o_pc, 5);

        tick(); tick();
        check("beq_pc", o_pc, 15); check("beq_retire", o_retire, 1);
        tick(); tick();
        check("wrap_taken_pc", o_pc, 1);
        i_run = 1'b0;

        // reset during the second MEM wait cycle of a load
        set_slot(0, enc(7, 2, 0, 0, 5));
        rst = 1'b1; tick(); rst = 1'b0; i_run = 1'b1;
        check("rst2_pc", o_pc, 0);
        tick(); tick();
        check("ab_req", o_mem_req, 1); check("ab_addr", o_mem_addr, 5);
        tick();
        check("ab_req_wait2", o_mem_req, 1);
        rst = 1'b1; i_mem_rdata = 32'h77;
        tick();
        rst = 1'b0; i_run = 1'b0; i_mem_ack = 1'b1;
        check("ab_req_off", o_mem_req, 0); check("ab_pc", o_pc, 0);
        tick(); i_mem_ack = 1'b0; i_mem_rdata = '0;
        check("late_ack_pc", o_pc, 0); check("late_ack_retire", o_retire, 0);
        check("late_ack_req", o_mem_req, 0);
        set_slot(0, enc(8, 0, 0, 2, 1));   // mem[1] = r2
        i_run = 1'b1;
        tick(); tick();
        check("ab_r2_addr", o_mem_addr, 1); check("ab_r2_zero", o_mem_wdata, 0);
        i_mem_ack = 1'b1;
        tick(); i_mem_ack = 1'b0;
        check("ab_st_pc", o_pc, 1);

        // not-taken compare at the last slot wraps to 0
        set_slot(1,  enc(9, 0, 0, 0, 14));
        set_slot(15, enc(10, 0, 0, 0, 2));
        tick(); tick();
        check("to15_pc", o_pc, 15);
        tick(); tick();
        check("wrap_nt_pc", o_pc, 0);
        i_run = 1'b0;

        // ten ALU instructions
        for (int k = 0; k < 10; k++) set_slot(k, enc(6, 1, 1, 0, 1));
        rst = 1'b1; tick(); rst = 1'b0; i_run = 1'b1;
        repeat (20) tick();
        i_run = 1'b0;
        check("perf_pc", o_pc, 10); check("perf_retire", o_retire, 1);
`ifdef CBS_MC_PERF_EN
        check("perf_retired", o_retired_count, 10);
        check("perf_cycles", o_cycle_count, 20);
`else
        check("perf_retired_off", o_retired_count, 0);
        check("perf_cycles_off", o_cycle_count, 0);
`endif
        tick();
        check("hold_pc", o_pc, 10); check("hold_retire", o_retire, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
